bcd_score_accum: RTL

Parametrised multi-digit BCD score accumulator for the game scoring path. It is the successor to the fixed 4-digit accumulator. It accepts a BCD hit score plus a combo multiplier over a valid/ready handshake and adds the score into a running total once per cycle, `mult` times. It adds overflow detection, optional saturation, a clear input and completion signalling. It sits between the hit-judgement logic and the score display driver.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_add.sv | 27 ++
 rtl/bcd_score_accum.sv | 114 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the score accumulator: digit width, digit limit,
// sequencer states and the digit clamp helper.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    function automatic logic [BCD_DIGIT_W-1:0] bcd_clamp(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit > BCD_NINE) ? BCD_NINE : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder. The operands are valid BCD digits, so the binary sum
// never exceeds 19 and a single +6 correction is enough.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] w_bin;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        w_bin = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        if (w_bin > 5'd9) begin
            s    = w_bin[BCD_DIGIT_W-1:0] + 4'd6;
            cout = 1'b1;
        end else begin
            s    = w_bin[BCD_DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_score_accum.sv
// Multi-digit BCD score accumulator: adds a latched hit score into the running
// total once per cycle, mult times. Define BCD_ACCUM_SAT_EN to saturate at all 9s.
module bcd_score_accum
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int MULT_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] in_score,
    input  logic [MULT_W-1:0]             in_mult,
    output logic [BCD_DIGIT_W*DIGITS-1:0] total,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int W = BCD_DIGIT_W * DIGITS;

    state_t            r_state;
    state_t            w_next_state;
    logic [W-1:0]      r_score;
    logic [W-1:0]      r_total;
    logic [W-1:0]      w_sum;
    logic [W-1:0]      w_score_clamped;
    logic [MULT_W-1:0] r_cnt;
    logic [DIGITS:0]   w_carry;
    logic              r_overflow;
    logic              r_done;
    logic              r_zero_pend;
    logic              w_accept;
    logic              w_last;

    assign w_carry[0] = 1'b0;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_add u_add (
            .a    (r_total[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .b    (r_score[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cin  (w_carry[g]),
            .s    (w_sum[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout (w_carry[g+1])
        );
        assign w_score_clamped[g*BCD_DIGIT_W +: BCD_DIGIT_W] =
            bcd_clamp(in_score[g*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_state == ADD) && (r_cnt == MULT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept && (in_mult != '0)) w_next_state = ADD;
                ADD:     if (r_cnt == MULT_W'(1))         w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == IDLE) && !clear && !rst;
        busy     = (r_state == ADD);
    end

    // NOTE: score and count are pure datapath qualified by state, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_score <= w_score_clamped;
            r_cnt   <= in_mult;
        end else if (r_state == ADD) begin
            r_cnt <= r_cnt - MULT_W'(1);
        end
    end

    // A zero-multiplier request still owes a done pulse, one cycle late.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_total     <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_zero_pend <= 1'b0;
        end else begin
            r_zero_pend <= w_accept && (in_mult == '0);
            r_done      <= r_zero_pend || w_last;
            if (r_state == ADD) begin
                r_overflow <= r_overflow | w_carry[DIGITS];
`ifdef BCD_ACCUM_SAT_EN
                r_total    <= w_carry[DIGITS] ? {DIGITS{BCD_NINE}} : w_sum;
`else
                r_total    <= w_sum;
`endif
            end
        end
    end

    assign total    = r_total;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule
